// File: rtl/touch_debounce.sv
// rtl/touch_debounce.sv - touch pad synchroniser, debouncer and long-press detector
module touch_debounce #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic touch_key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_hold
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int LONG_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_DEB = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               s0_q, s0_d;
    logic               s1_q, s1_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [LONG_W-1:0]  long_cnt_q, long_cnt_d;
    logic               key_level_q, key_level_d;
    logic               key_press_q, key_press_d;
    logic               key_release_q, key_release_d;
    logic               key_long_q, key_long_d;
    logic               key_hold_q, key_hold_d;

    // State register: sync chain, FSM, counters and registered outputs
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            s0_q          <= 1'b0;
            s1_q          <= 1'b0;
            deb_cnt_q     <= '0;
            long_cnt_q    <= '0;
            key_level_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_long_q    <= 1'b0;
            key_hold_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            deb_cnt_q     <= deb_cnt_d;
            long_cnt_q    <= long_cnt_d;
            key_level_q   <= key_level_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            key_long_q    <= key_long_d;
            key_hold_q    <= key_hold_d;
        end
    end

    // Next-state logic: stability counting, long-press timer and output pulses
    always_comb begin
        state_d       = state_q;
        s0_d          = touch_key;
        s1_d          = s0_q;
        deb_cnt_d     = deb_cnt_q;
        long_cnt_d    = long_cnt_q;
        key_level_d   = key_level_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        key_long_d    = 1'b0;
        key_hold_d    = key_hold_q;

        // The long timer runs through release bounce so a shaky release
        // does not restart it; it saturates once the threshold is hit.
        if (state_q == PRESSED || state_q == RELEASE_DEB) begin
            if (long_cnt_q == LONG_LAST) begin
                if (!key_hold_q) begin
                    key_long_d = 1'b1;
                    key_hold_d = 1'b1;
                end
            end else begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (s1_q) begin
                    state_d   = PRESS_DEB;
                    deb_cnt_d = '0;
                end
            end
            PRESS_DEB: begin
                if (!s1_q) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    deb_cnt_d   = '0;
                    key_level_d = 1'b1;
                    key_press_d = 1'b1;
                    long_cnt_d  = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (!s1_q) begin
                    state_d   = RELEASE_DEB;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_DEB: begin
                if (s1_q) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    // Release wins over a coincident long-press threshold.
                    state_d       = IDLE;
                    deb_cnt_d     = '0;
                    key_level_d   = 1'b0;
                    key_release_d = 1'b1;
                    key_long_d    = 1'b0;
                    key_hold_d    = 1'b0;
                    long_cnt_d    = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign key_level   = key_level_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign key_long    = key_long_q;
    assign key_hold    = key_hold_q;

endmodule

// File: tb/tb_touch_debounce.sv
// tb/tb_touch_debounce.sv - self-checking bench for touch_debounce
module tb_touch_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    typedef enum int {
        EV_PRESS, EV_LVL_UP, EV_LONG, EV_HOLD_UP, EV_RELEASE, EV_LVL_DN, EV_HOLD_DN
    } ev_kind_t;

    typedef struct {
        int       at;
        ev_kind_t kind;
    } ev_t;

    typedef struct {
        int high_cycles;
        bit exp_press;
        bit exp_long;
    } vec_t;

    logic clk_50m;
    logic rst;
    logic touch_key;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;
    logic key_hold;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic prev_level = 1'b0;
    logic prev_hold  = 1'b0;

    touch_debounce #(
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .touch_key   (touch_key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_hold    (key_hold)
    );

    initial begin
        clk_50m = 1'b0;
        forever #5 clk_50m = ~clk_50m;
    end

    always @(posedge clk_50m) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic push(input int at, input ev_kind_t kind);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got %s at edge %0d, required no event", kind.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.at != cyc || e.kind != kind) begin
                errors++;
                $display("FAIL event_seq: got %s at edge %0d, required %s at edge %0d",
                         kind.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Output monitor: every pulse and level transition must match the next expected event
    always @(posedge clk_50m) begin
        #1;
        if (rst) begin
            prev_level = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (key_press) chk("press_release_exclusive", key_release, 1'b0);
            if (key_press)                observe(EV_PRESS);
            if (key_level && !prev_level) observe(EV_LVL_UP);
            if (key_long)                 observe(EV_LONG);
            if (key_hold && !prev_hold)   observe(EV_HOLD_UP);
            if (key_release)              observe(EV_RELEASE);
            if (!key_level && prev_level) observe(EV_LVL_DN);
            if (!key_hold && prev_hold)   observe(EV_HOLD_DN);
            prev_level = key_level;
            prev_hold  = key_hold;
        end
    end

    // One press of high_cycles samples from idle, then a long quiet low period
    task automatic run_vec(input vec_t v);
        int k;
        int r;
        @(negedge clk_50m);
        touch_key = 1'b1;
        k = cyc + 1;
        r = k + v.high_cycles + 2 + DEB;
        if (v.exp_press) begin
            push(k + 2 + DEB, EV_PRESS);
            push(k + 2 + DEB, EV_LVL_UP);
        end
        if (v.exp_long) begin
            push(k + 2 + DEB + LONG, EV_LONG);
            push(k + 2 + DEB + LONG, EV_HOLD_UP);
        end
        if (v.exp_press) begin
            push(r, EV_RELEASE);
            push(r, EV_LVL_DN);
        end
        if (v.exp_long) push(r, EV_HOLD_DN);
        repeat (v.high_cycles - 1) @(negedge clk_50m);
        @(negedge clk_50m);
        touch_key = 1'b0;
        repeat (39) @(negedge clk_50m);
        chk("idle_level", key_level, 1'b0);
        chk("idle_hold", key_hold, 1'b0);
    endtask

    initial begin
        vec_t vecs[7];
        int   k;
        int   m;

        vecs[0] = '{3,  1'b0, 1'b0};
        vecs[1] = '{4,  1'b0, 1'b0};
        vecs[2] = '{5,  1'b1, 1'b0};
        vecs[3] = '{10, 1'b1, 1'b0};
        vecs[4] = '{20, 1'b1, 1'b0};
        vecs[5] = '{21, 1'b1, 1'b1};
        vecs[6] = '{30, 1'b1, 1'b1};

        rst       = 1'b1;
        touch_key = 1'b0;
        repeat (3) @(negedge clk_50m);
        chk("reset_level", key_level, 1'b0);
        chk("reset_press", key_press, 1'b0);
        chk("reset_release", key_release, 1'b0);
        chk("reset_long", key_long, 1'b0);
        chk("reset_hold", key_hold, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk_50m);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Release bounce: low 2, high 1, then low for good from edge m
        @(negedge clk_50m);
        touch_key = 1'b1;
        k = cyc + 1;
        push(k + 2 + DEB, EV_PRESS);
        push(k + 2 + DEB, EV_LVL_UP);
        repeat (9) @(negedge clk_50m);
        @(negedge clk_50m);
        touch_key = 1'b0;
        @(negedge clk_50m);
        @(negedge clk_50m);
        touch_key = 1'b1;
        @(negedge clk_50m);
        touch_key = 1'b0;
        m = cyc + 1;
        push(m + 2 + DEB, EV_RELEASE);
        push(m + 2 + DEB, EV_LVL_DN);
        repeat (39) @(negedge clk_50m);
        chk("bounce_idle_level", key_level, 1'b0);

        // Asynchronous reset in PRESSED, then a held key is a fresh press
        @(negedge clk_50m);
        touch_key = 1'b1;
        k = cyc + 1;
        push(k + 2 + DEB, EV_PRESS);
        push(k + 2 + DEB, EV_LVL_UP);
        repeat (11) @(negedge clk_50m);
        chk("pre_reset_level", key_level, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_level", key_level, 1'b0);
        chk("async_rst_press", key_press, 1'b0);
        chk("async_rst_release", key_release, 1'b0);
        chk("async_rst_long", key_long, 1'b0);
        chk("async_rst_hold", key_hold, 1'b0);
        chk_int("queue_before_reset", exp_q.size(), 0);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;
        k = cyc + 1;
        push(k + 2 + DEB, EV_PRESS);
        push(k + 2 + DEB, EV_LVL_UP);
        push(k + 2 + DEB + LONG, EV_LONG);
        push(k + 2 + DEB + LONG, EV_HOLD_UP);
        repeat (29) @(negedge clk_50m);
        chk("post_reset_hold", key_hold, 1'b1);
        @(negedge clk_50m);
        touch_key = 1'b0;
        m = cyc + 1;
        push(m + 2 + DEB, EV_RELEASE);
        push(m + 2 + DEB, EV_LVL_DN);
        push(m + 2 + DEB, EV_HOLD_DN);
        repeat (39) @(negedge clk_50m);

        chk_int("queue_empty_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/touch_debounce.md
Name: touch_debounce

Overview:
Conditions the raw capacitive touch pad input before the touch toggle stage.
- Synchronises the asynchronous pad level into the clk_50m domain.
- Filters contact bounce and glitches with a counter-based stability check.
- Outputs a clean debounced level, single-cycle press/release pulses, and a long-press pulse/level.
- key_level feeds the downstream toggle stage's rising-edge detector; the pulses are available to other control logic.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range >= 2.
LONG_CYCLES, 50000000, cycles in the pressed condition before long press is flagged (1 s at 50 MHz); must be > DEB_CYCLES.

Ports:
clk_50m  input  1  system clock, 50 MHz, all logic on rising edge
rst  input  1  asynchronous active-high reset
touch_key  input  1  raw touch pad level, asynchronous, active high
key_level  output  1  debounced key level, 1 = pressed
key_press  output  1  one-cycle pulse when a press is accepted
key_release  output  1  one-cycle pulse when a release is accepted
key_long  output  1  one-cycle pulse when press duration reaches LONG_CYCLES
key_hold  output  1  level, high from key_long until release is accepted

Behaviour:
- Clock and reset: one clock, clk_50m. Reset is asynchronous and active-high. While rst = 1, all flops clear immediately: sync flops, FSM = IDLE, counters = 0, all outputs = 0. All outputs are registered.
- Synchroniser: two flops, s0 <= touch_key, s1 <= s0. The FSM uses only s1.
- Counter widths: deb_cnt is $clog2(DEB_CYCLES) bits; long_cnt is $clog2(LONG_CYCLES) bits.
- FSM states: IDLE, PRESS_DEB, PRESSED, RELEASE_DEB.
- IDLE:
  - s1 = 1 -> PRESS_DEB, deb_cnt = 0.
- PRESS_DEB:
  - s1 = 0 -> IDLE, deb_cnt = 0, no output change.
  - s1 = 1 and deb_cnt == DEB_CYCLES-1 -> PRESSED. key_level = 1, key_press = 1 for this cycle, long_cnt = 0.
  - Otherwise deb_cnt increments.
- PRESSED:
  - long_cnt increments each cycle until long_cnt == LONG_CYCLES-1.
  - On that edge: key_long = 1 for one cycle, key_hold = 1, long_cnt then saturates (no further key_long).
  - s1 = 0 -> RELEASE_DEB, deb_cnt = 0.
- RELEASE_DEB:
  - long_cnt keeps counting with the same rule as PRESSED, so release bounce does not restart the long timer.
  - s1 = 1 -> back to PRESSED, deb_cnt = 0.
  - s1 = 0 and deb_cnt == DEB_CYCLES-1 -> IDLE. key_level = 0, key_release = 1 for one cycle, key_hold = 0, long_cnt = 0.
  - Otherwise deb_cnt increments.
- Latency: if touch_key is first sampled high at edge k and stays high, key_press and key_level rise at edge k+2+DEB_CYCLES. Release is symmetric: first low sample at edge m gives key_release at edge m+2+DEB_CYCLES.
- Glitch rejection: any excursion of s1 shorter than DEB_CYCLES cycles produces no output change.
- Simultaneous events: if release acceptance and the long threshold fall on the same edge, release wins. key_release pulses; key_long is not emitted and key_hold stays 0.
- Pulse rules:
  - key_press and key_release are never high in the same cycle.
  - Each accepted press gives exactly one key_press and at most one key_long.
  - Each accepted press is followed by exactly one key_release.
- Reset mid-operation: pulses in flight are dropped. If touch_key is still high after rst deasserts, it is treated as a new press with full latency.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20):
1. touch_key rises, first sampled at edge 10, held high -> key_press single pulse at edge 16; key_level 1 from edge 16; key_long pulse at edge 36, key_hold 1 from 36.
2. touch_key high for 3 cycles, then low -> key_press, key_level, key_release stay 0 throughout; FSM returns to IDLE.
3. While pressed: touch_key low 2 cycles, high 1 cycle, then low from edge m -> exactly one key_release at edge m+6; key_level falls at m+6; no extra key_press.
4. Press accepted at edge P, touch_key released so release is accepted at P+10 -> key_long never asserts; key_hold stays 0; key_release pulses once.
5. Long press (key_hold = 1), then release -> key_hold and key_level fall on the same edge that key_release pulses.
6. rst asserted asynchronously mid-PRESSED -> all outputs 0 before the next clock edge. After deassert with touch_key held high: new key_press exactly 2+4 edges after the first sampling edge; key_long 20 edges after that.
